// File: rtl/wb_dbg_pkg.sv
// Shared command/response codes and FSM state encoding for the Wishbone debug master.
package wb_dbg_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_OK  = 8'hAA;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_ADDR  = 3'd1;
    localparam logic [2:0] ENC_WDATA = 3'd2;
    localparam logic [2:0] ENC_BUS   = 3'd3;
    localparam logic [2:0] ENC_RESP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ADDR  = ENC_ADDR,
        ST_WDATA = ENC_WDATA,
        ST_BUS   = ENC_BUS,
        ST_RESP  = ENC_RESP
    } state_e;

endpackage

// File: rtl/wb_dbg_txser.sv
// Word-to-byte serializer: loads up to four bytes and streams them MSB first over valid/ready.
module wb_dbg_txser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last
);
    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;

    assign tx_data  = word_q[31:24];
    assign tx_valid = (cnt_q != 3'd0);
    assign tx_last  = (cnt_q == 3'd1);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = load_word;
            cnt_d  = load_cnt;
        end else if (tx_valid && tx_ready) begin
            word_d = {word_q[23:0], 8'h00};
            cnt_d  = cnt_q - 3'd1;
        end
    end

    // NOTE: synchronous reset, so rst only appears inside the clocked branch, never in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_dbg_master.sv
// Byte-stream command parser that runs single 32-bit Wishbone cycles and returns status or read data.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int timeout_cycles = 1024,
    parameter int tmo_width      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy
);
    localparam logic [tmo_width-1:0] TMO_LAST = tmo_width'(timeout_cycles - 1);

    state_e               state_q, state_d;
    logic [1:0]           byte_q, byte_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 we_q, we_d;
    logic [tmo_width-1:0] tmo_q, tmo_d;

    logic        load;
    logic [31:0] load_word;
    logic [2:0]  load_cnt;
    logic        tx_last;

    assign wb_cyc_o = (state_q == ST_BUS);
    assign wb_stb_o = wb_cyc_o;
    assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign busy     = (state_q != ST_IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        tmo_d     = tmo_q;
        load      = 1'b0;
        load_word = '0;
        load_cnt  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    we_d    = (rx_data == CMD_WR);
                    byte_d  = 2'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    adr_d  = {adr_q[23:0], rx_data};
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = we_q ? ST_WDATA : ST_BUS;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    dat_d  = {dat_q[23:0], rx_data};
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                tmo_d = tmo_q + 1'b1;
                // Retry is reported as an error; error wins over a simultaneous ack.
                if (wb_err_i || wb_rty_i) begin
                    load      = 1'b1;
                    load_word = {RSP_ERR, 24'h0};
                    load_cnt  = 3'd1;
                    state_d   = ST_RESP;
                end else if (wb_ack_i) begin
                    load      = 1'b1;
                    load_word = we_q ? {RSP_OK, 24'h0} : wb_dat_i;
                    load_cnt  = we_q ? 3'd1 : 3'd4;
                    state_d   = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    load      = 1'b1;
                    load_word = {RSP_ERR, 24'h0};
                    load_cnt  = 3'd1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_valid && tx_ready && tx_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
        end
    end

    wb_dbg_txser u_txser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word (load_word),
        .load_cnt  (load_cnt),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last)
    );

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master with a 16-cycle bus timeout.
module tb_wb_dbg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    wb_dbg_master #(.timeout_cycles(16), .tmo_width(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic slave_pulse(input logic ack, input logic err, input logic [31:0] dat);
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = dat;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
    endtask

    // Collects n transmitted bytes MSB first; tx_ready toggles 0/1 when toggle is set.
    task automatic get_bytes(input int n, input bit toggle, output logic [31:0] word,
                             output bit stable_ok, output bit timed_out);
        int         got  = 0;
        bit         pend = 1'b0;
        logic [7:0] held = 8'h00;
        word      = 32'h0;
        stable_ok = 1'b1;
        timed_out = 1'b0;
        for (int i = 0; i < 200 && got < n; i++) begin
            tx_ready = toggle ? i[0] : 1'b1;
            if (pend && (!tx_valid || tx_data !== held)) stable_ok = 1'b0;
            pend = 1'b0;
            if (tx_valid && tx_ready) begin
                word = {word[23:0], tx_data};
                got++;
            end else if (tx_valid) begin
                pend = 1'b1;
                held = tx_data;
            end
            step();
        end
        tx_ready = 1'b1;
        if (got < n) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tx=%h v=%b adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b busy=%b, expected all 0",
                     tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        logic [31:0] w;
        bit st, to;
        bit cyc_ok = 1'b1;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b111_1111) begin
            failures++;
            $display("FAIL wr_bus_ctrl: got cyc=%b stb=%b we=%b sel=%h, expected 1 1 1 f",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
        end
        checks++;
        if (wb_adr_o !== 32'h0000_4000 || wb_dat_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_adr_dat: got adr=%h dat=%h, expected 00004000 deadbeef", wb_adr_o, wb_dat_o);
        end
        for (int i = 0; i < 3; i++) begin
            if (!wb_cyc_o || tx_valid) cyc_ok = 1'b0;
            step();
        end
        slave_pulse(1'b1, 1'b0, 32'h0);
        checks++;
        if (!cyc_ok || wb_cyc_o !== 1'b0 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack_end: got held=%b cyc=%b tx_valid=%b, expected 1 0 1", cyc_ok, wb_cyc_o, tx_valid);
        end
        get_bytes(1, 1'b0, w, st, to);
        checks++;
        if (to || w !== 32'h0000_00AA) begin
            failures++;
            $display("FAIL wr_status: got %h timeout=%b, expected 000000aa timeout=0", w, to);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle: got tx_valid=%b busy=%b, expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] w;
        bit st, to;
        send_byte(8'h02);
        send_byte(8'h70); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0 || wb_adr_o !== 32'h7000_0000) begin
            failures++;
            $display("FAIL rd_bus: got cyc=%b we=%b adr=%h, expected 1 0 70000000", wb_cyc_o, wb_we_o, wb_adr_o);
        end
        step();
        slave_pulse(1'b1, 1'b0, 32'h1234_5678);
        get_bytes(4, 1'b1, w, st, to);
        checks++;
        if (to || w !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_data: got %h timeout=%b, expected 12345678 timeout=0", w, to);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("FAIL rd_stall_hold: got tx_data changed during stall, expected stable");
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_idle: got tx_valid=%b busy=%b, expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        bit st, to;
        int n = 0;
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 100 && wb_cyc_o; i++) begin
            n++;
            step();
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL tmo_cycles: got cyc high %0d cycles, expected 16", n);
        end
        get_bytes(1, 1'b0, w, st, to);
        checks++;
        if (to || w !== 32'h0000_00EE) begin
            failures++;
            $display("FAIL tmo_status: got %h timeout=%b, expected 000000ee timeout=0", w, to);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_err_priority();
        logic [31:0] w;
        bit st, to;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        step();
        slave_pulse(1'b1, 1'b1, 32'h0);
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL err_drop: got cyc=%b stb=%b, expected 0 0", wb_cyc_o, wb_stb_o);
        end
        get_bytes(1, 1'b0, w, st, to);
        checks++;
        if (to || w !== 32'h0000_00EE) begin
            failures++;
            $display("FAIL err_status: got %h timeout=%b, expected 000000ee timeout=0", w, to);
        end
    endtask

    task automatic test_garbage();
        logic [31:0] w;
        bit st, to;
        send_byte(8'h55);
        send_byte(8'h00);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL garbage_drop: got busy=%b, expected 0", busy);
        end
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        slave_pulse(1'b1, 1'b0, 32'hCAFE_F00D);
        get_bytes(4, 1'b0, w, st, to);
        checks++;
        if (to || w !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL garbage_rd: got %h timeout=%b, expected cafef00d timeout=0", w, to);
        end
    endtask

    task automatic test_reset_in_bus();
        logic [31:0] w;
        bit st, to;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bus_reset: got cyc=%b stb=%b tx_valid=%b busy=%b, expected 0 0 0 0",
                     wb_cyc_o, wb_stb_o, tx_valid, busy);
        end
        send_byte(8'h02);
        send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0); send_byte(8'hD0);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'hA0B0_C0D0) begin
            failures++;
            $display("FAIL post_reset_bus: got cyc=%b adr=%h, expected 1 a0b0c0d0", wb_cyc_o, wb_adr_o);
        end
        slave_pulse(1'b1, 1'b0, 32'h0BAD_CAFE);
        get_bytes(4, 1'b0, w, st, to);
        checks++;
        if (to || w !== 32'h0BAD_CAFE) begin
            failures++;
            $display("FAIL post_reset_rd: got %h timeout=%b, expected 0badcafe timeout=0", w, to);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        #1;
        test_reset();
        test_write();
        test_read_stall();
        test_timeout();
        test_err_priority();
        test_garbage();
        test_reset_in_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
